// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and flag bit positions for alu_pipe.
// The ALU_MUL_EN macro, when defined, makes op 8 a multi-cycle multiply.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;
    localparam int FLAG_ERR   = 4;
    localparam int NUM_FLAGS  = 5;

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier, one partial product per enabled cycle.
// Only instantiated by alu_pipe when ALU_MUL_EN is defined.
module alu_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] step_acc;

    // The last partial product is folded in combinationally so the caller
    // can capture the full product on the same edge that retires the count.
    assign step_acc = acc + (mplier[0] ? mcand : '0);
    assign done     = busy & (count == CW'(WIDTH - 1));
    assign product  = step_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (en) begin
            if (start) begin
                busy   <= 1'b1;
                count  <= '0;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
            end else if (busy) begin
                acc    <= step_acc;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
                if (done) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes and a single-entry output register.
// Define ALU_MUL_EN to enable the multi-cycle unsigned multiply on op 8.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             ovf_flag,
    output logic             err_flag
);
    localparam int SHW = $clog2(WIDTH);

    state_t                 state, state_next;
    logic                   accept, transfer, load_alu;
    logic [WIDTH-1:0]       res_q, hi_q;
    logic [NUM_FLAGS-1:0]   flags_q;
    logic [WIDTH-1:0]       alu_res;
    logic [NUM_FLAGS-1:0]   alu_flags;
    logic [WIDTH:0]         wide;
    logic [SHW-1:0]         shamt;
    logic                   alu_carry, alu_ovf, alu_err;

    assign in_ready = en & ((state == S_IDLE) | ((state == S_HOLD) & out_ready));
    assign accept   = in_valid & in_ready;
    assign transfer = (state == S_HOLD) & out_ready & en;
    assign shamt    = b[SHW-1:0];

`ifdef ALU_MUL_EN
    logic               mul_start, mul_busy, mul_done, load_mul, is_mul_op;
    logic [2*WIDTH-1:0] mul_product;

    assign is_mul_op = (op == OP_MUL);
    assign mul_start = accept & is_mul_op;
    assign load_mul  = (state == S_BUSY) & en & mul_done;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    logic is_mul_op;
    assign is_mul_op = 1'b0;
`endif

    // Single-cycle datapath; shifts run one bit wider so the bit that falls
    // off the end lands in a known position and becomes the carry.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        wide      = '0;
        case (op)
            OP_ADD: begin
                wide      = {1'b0, a} + {1'b0, b};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) & (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide      = {1'b0, a} - {1'b0, b};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) & (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                wide      = {1'b0, a} << shamt;
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
            end
            OP_SHR: begin
                wide      = {a, 1'b0} >> shamt;
                alu_res   = wide[WIDTH:1];
                alu_carry = wide[0];
            end
            default: alu_err = 1'b1;
        endcase
        alu_flags             = '0;
        alu_flags[FLAG_CARRY] = alu_carry;
        alu_flags[FLAG_ZERO]  = ~alu_err & (alu_res == '0);
        alu_flags[FLAG_NEG]   = alu_res[WIDTH-1];
        alu_flags[FLAG_OVF]   = alu_ovf;
        alu_flags[FLAG_ERR]   = alu_err;
    end

    always_comb begin
        state_next = state;
        load_alu   = 1'b0;
        case (state)
            S_IDLE, S_HOLD: begin
                if (accept) begin
                    if (is_mul_op) begin
                        state_next = S_BUSY;
                    end else begin
                        state_next = S_HOLD;
                        load_alu   = 1'b1;
                    end
                end else if (transfer) begin
                    state_next = S_IDLE;
                end
            end
            S_BUSY: begin
`ifdef ALU_MUL_EN
                if (load_mul) begin
                    state_next = S_HOLD;
                end
`else
                state_next = S_IDLE;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result and flags are written together so they always describe one op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else if (load_alu) begin
            res_q   <= alu_res;
            hi_q    <= '0;
            flags_q <= alu_flags;
`ifdef ALU_MUL_EN
        end else if (load_mul) begin
            res_q                <= mul_product[WIDTH-1:0];
            hi_q                 <= mul_product[2*WIDTH-1:WIDTH];
            flags_q              <= '0;
            flags_q[FLAG_CARRY]  <= |mul_product[2*WIDTH-1:WIDTH];
            flags_q[FLAG_ZERO]   <= (mul_product == '0);
            flags_q[FLAG_NEG]    <= mul_product[WIDTH-1];
`endif
        end
    end

    assign out_valid = (state == S_HOLD);
    assign result    = res_q;
    assign result_hi = hi_q;
    assign carry_out = flags_q[FLAG_CARRY];
    assign zero_flag = flags_q[FLAG_ZERO];
    assign neg_flag  = flags_q[FLAG_NEG];
    assign ovf_flag  = flags_q[FLAG_OVF];
    assign err_flag  = flags_q[FLAG_ERR];

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=4: directed cases plus random ops
// against an arithmetic reference model. Honours ALU_MUL_EN when defined.
module tb_alu_pipe;
    localparam int WIDTH = 4;
    localparam int LIM   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst, en, in_valid, out_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] result, result_hi;
    logic             carry_out, zero_flag, neg_flag, ovf_flag, err_flag;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] hi;
        logic             carry;
        logic             zero;
        logic             neg;
        logic             ovf;
        logic             err;
    } exp_t;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry_out (carry_out),
        .zero_flag (zero_flag),
        .neg_flag  (neg_flag),
        .ovf_flag  (ovf_flag),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    // Expected outputs from plain integer arithmetic on the op definitions.
    function automatic exp_t refModel(input int opc, input int av, input int bv);
        exp_t e;
        int   sa, sb, s, full;
        bit   is_mul;
        e      = '0;
        is_mul = 1'b0;
        sa     = (av >= LIM / 2) ? av - LIM : av;
        sb     = (bv >= LIM / 2) ? bv - LIM : bv;
        s      = bv % WIDTH;
        case (opc)
            0: begin
                full    = av + bv;
                e.res   = WIDTH'(full % LIM);
                e.carry = (full >= LIM);
                e.ovf   = ((sa + sb) > LIM / 2 - 1) || ((sa + sb) < -(LIM / 2));
            end
            1: begin
                full    = av - bv;
                e.res   = WIDTH'((full + LIM) % LIM);
                e.carry = (av < bv);
                e.ovf   = ((sa - sb) > LIM / 2 - 1) || ((sa - sb) < -(LIM / 2));
            end
            2: e.res = WIDTH'(av & bv);
            3: e.res = WIDTH'(av | bv);
            4: e.res = WIDTH'(av ^ bv);
            5: e.res = WIDTH'(LIM - 1 - av);
            6: begin
                e.res   = WIDTH'((av << s) % LIM);
                e.carry = (s == 0) ? 1'b0 : 1'(((av >> (WIDTH - s)) & 1));
            end
            7: begin
                e.res   = WIDTH'(av >> s);
                e.carry = (s == 0) ? 1'b0 : 1'(((av >> (s - 1)) & 1));
            end
`ifdef ALU_MUL_EN
            8: begin
                is_mul  = 1'b1;
                full    = av * bv;
                e.res   = WIDTH'(full % LIM);
                e.hi    = WIDTH'(full / LIM);
                e.carry = (full / LIM) != 0;
                e.zero  = (full == 0);
                e.neg   = e.res[WIDTH-1];
            end
`endif
            default: e.err = 1'b1;
        endcase
        if (!e.err && !is_mul) begin
            e.zero = (e.res == '0);
            e.neg  = e.res[WIDTH-1];
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkFields(input string tag, input exp_t e);
        checkOutput({tag, ".result"},    result,    e.res);
        checkOutput({tag, ".result_hi"}, result_hi, e.hi);
        checkOutput({tag, ".carry"},     carry_out, e.carry);
        checkOutput({tag, ".zero"},      zero_flag, e.zero);
        checkOutput({tag, ".neg"},       neg_flag,  e.neg);
        checkOutput({tag, ".ovf"},       ovf_flag,  e.ovf);
        checkOutput({tag, ".err"},       err_flag,  e.err);
    endtask

    // Issue one op from IDLE, check latency and outputs, stall, then drain.
    task automatic applyStimulus(input int opc, input int av, input int bv, input int hold);
        exp_t  e;
        int    lat, explat;
        string tag;
        tag    = $sformatf("op%0d(%0d,%0d)", opc, av, bv);
        e      = refModel(opc, av, bv);
        explat = 1;
`ifdef ALU_MUL_EN
        if (opc == 8) explat = WIDTH;
`endif
        @(negedge clk);
        op        = 4'(opc);
        a         = WIDTH'(av);
        b         = WIDTH'(bv);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1 checkOutput({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 4 * WIDTH) begin
            checkOutput({tag, ".busy_in_ready"}, in_ready, 0);
            @(posedge clk);
            #1 lat++;
        end
        checkOutput({tag, ".latency"}, lat, explat);
        checkOutput({tag, ".out_valid"}, out_valid, 1);
        checkFields(tag, e);
        repeat (hold) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".hold_valid"},    out_valid, 1);
            checkOutput({tag, ".hold_result"},   result,    e.res);
            checkOutput({tag, ".hold_carry"},    carry_out, e.carry);
            checkOutput({tag, ".hold_in_ready"}, in_ready,  0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checkOutput({tag, ".drained"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e1, e2;
        rst       = 1'b1;
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;

        #1;
        checkOutput("reset.in_ready",  in_ready,  1);
        checkOutput("reset.out_valid", out_valid, 0);
        checkOutput("reset.result",    result,    0);
        checkOutput("reset.err",       err_flag,  0);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted while a result is pending.
        @(negedge clk);
        op = 4'd0; a = 4'd3; b = 4'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checkOutput("prehold.out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_hold.out_valid", out_valid, 0);
        checkOutput("rst_hold.result",    result,    0);
        @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("post_rst.in_ready", in_ready, 1);

        applyStimulus(0, 9, 3, 0);
        applyStimulus(1, 9, 3, 0);
        applyStimulus(0, 15, 1, 0);
        applyStimulus(6, 9, 1, 0);
        applyStimulus(7, 9, 0, 0);
        applyStimulus(15, 7, 7, 0);
        applyStimulus(8, 9, 3, 0);

        // Backpressure for three cycles, then same-cycle transfer and accept.
        e1 = refModel(0, 5, 6);
        e2 = refModel(4, 12, 10);
        @(negedge clk);
        op = 4'd0; a = 4'd5; b = 4'd6; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("bp.out_valid", out_valid, 1);
            checkOutput("bp.result",    result,    e1.res);
            checkOutput("bp.ovf",       ovf_flag,  e1.ovf);
            checkOutput("bp.in_ready",  in_ready,  0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = 4'd4; a = 4'd12; b = 4'd10;
        #1 checkOutput("b2b.in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b.out_valid", out_valid, 1);
        checkFields("b2b", e2);

        // Enable low while holding: out_ready is ignored and nothing moves.
        en = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1 checkOutput("en0.in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("en0.out_valid", out_valid, 1);
        checkOutput("en0.result",    result,    e2.res);
        in_valid = 1'b0;
        en = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checkOutput("en1.drained", out_valid, 0);

        // Enable low in IDLE with a valid op presented.
        en = 1'b0;
        in_valid = 1'b1;
        op = 4'd0; a = 4'd1; b = 4'd1;
        #1 checkOutput("en0_idle.in_ready", in_ready, 0);
        @(posedge clk);
        #1 checkOutput("en0_idle.out_valid", out_valid, 0);
        in_valid = 1'b0;
        en = 1'b1;

`ifdef ALU_MUL_EN
        // Reset mid-multiply aborts it; a fresh multiply still works.
        @(negedge clk);
        op = 4'd8; a = 4'd7; b = 4'd5; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("rst_busy.out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("rst_busy.in_ready", in_ready, 1);
        applyStimulus(8, 15, 15, 1);
`endif

        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, LIM - 1)),
                          int'($urandom_range(0, LIM - 1)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the team's 4-bit clock-enabled ALU.
- Adds WIDTH generalisation, a valid/ready handshake on input and output, and a registered single-entry output with backpressure.
- Adds signed overflow and negative flags, barrel shifts, an illegal-op error flag, and an optional multi-cycle multiply.
- Sits between an operand/issue stage and a result consumer in the datapath.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2, power of two).
- SHW, $clog2(WIDTH), shift-amount width (localparam, derived; not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; 0 freezes all state.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept this cycle.
- op  in  4  operation code.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; low SHW bits give the shift amount for shifts.
- out_valid  out  1  result registered and pending.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  result (low half for MUL).
- result_hi  out  WIDTH  high half of product; 0 for non-MUL ops.
- carry_out  out  1  carry, borrow, or shifted-out bit.
- zero_flag  out  1  result (and result_hi for MUL) all zero.
- neg_flag  out  1  result[WIDTH-1].
- ovf_flag  out  1  signed overflow.
- err_flag  out  1  illegal op.

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high, port rst.
- Reset values:
  - FSM goes to IDLE; any multiply in flight is aborted.
  - All outputs are 0, except in_ready, which follows its combinational rule (1 in IDLE with en=1).
- FSM states: IDLE, BUSY (multiply iterating), HOLD (result pending).
- in_ready = en & (IDLE | (HOLD & out_ready)). Accept occurs when in_valid & in_ready.
- Output transfer occurs when out_valid & out_ready & en. A same-cycle transfer and accept is allowed; the new result replaces the old one with no bubble.
- HOLD with out_ready=0: result and flags stay stable; out_valid stays 1.
- en=0: no state change, no accept, no transfer. out_ready is ignored.
- Single-cycle ops: the result is registered on the accept edge, so out_valid=1 the next cycle (latency 1). FSM moves to HOLD.
- Op codes and results:
  - 0 ADD: a+b. carry = unsigned carry out. ovf = signed overflow.
  - 1 SUB: a-b. carry = borrow (a<b unsigned). ovf = signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT(a): carry=0, ovf=0.
  - 6 SHL by b[SHW-1:0]: carry = last bit shifted out; 0 if the amount is 0. ovf=0.
  - 7 SHR logical, same carry rule as SHL.
  - 8 MUL: see Optional Feature.
  - 9-15: illegal. result=0, result_hi=0, err_flag=1, other flags 0. zero_flag=0 on an error.
- err_flag is 0 for all legal ops.
- Arithmetic is computed at WIDTH+1 bits internally; results truncate to WIDTH.
- Flags register together with the result and always describe the currently presented result.
- Reset asserted mid-BUSY or mid-HOLD: the result is lost and out_valid drops immediately.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - op 8 is an unsigned WIDTH×WIDTH shift-add multiply, one partial product per cycle.
  - Accept edge loads operands and enters BUSY. Internal counter runs 0..WIDTH-1.
  - On the WIDTH-th edge after accept, the output register is written and the FSM enters HOLD, so out_valid appears WIDTH cycles after accept.
  - Outputs: result = product low half, result_hi = product high half.
  - Flags: carry = |result_hi, ovf=0, neg = result[WIDTH-1], zero = product==0.
  - in_ready=0 throughout BUSY.
- Undefined: op 8 is illegal (err_flag=1). No BUSY state and no counter logic are synthesised.

Decomposition:
- Package alu_pkg:
  - op-code localparams OP_ADD…OP_MUL;
  - FSM state encodings S_IDLE/S_BUSY/S_HOLD;
  - flag-bit index constants.
- Sub-module alu_seq_mul (WIDTH):
  - start/busy/done plus shift-add datapath;
  - instantiated only under ALU_MUL_EN.

Test Plan (WIDTH=4):
- Reset mid-HOLD; ADD flags:
  - Stimulus: rst=1 asserted mid-HOLD.
  - Response: out_valid→0 asynchronously. After release, IDLE with in_ready=1.
  - Stimulus: then ADD a=9, b=3.
  - Response: result=12 next cycle; carry=0, zero=0, neg=1, ovf=0.
- SUB and ADD wrap:
  - SUB a=9, b=3 → result=6, carry=0, ovf=1.
  - ADD a=15, b=1 → result=0, carry=1, zero=1.
- Shifts:
  - SHL a=9, b=1 → result=2, carry=1.
  - SHR a=9, b=0 → result=9, carry=0.
- Backpressure and back-to-back:
  - out_ready=0 for 3 cycles after an ADD: result/flags stable, in_ready=0.
  - Raise out_ready with a new op valid: transfer and accept in the same cycle.
- Illegal op and enable:
  - op=15 → result=0, err_flag=1.
  - en=0 with in_valid=1 → in_ready=0, no state change.
- MUL with ALU_MUL_EN:
  - a=9, b=3 → out_valid exactly 4 cycles after accept; result=11, result_hi=1, carry=1.
  - in_ready=0 during BUSY.
  - Without ALU_MUL_EN, op=8 → err_flag=1.
